dmem_arb: RTL and testbench

- Arbitrates the single-port data memory between the pipeline MA stage and an external requester (debug loader / DMA).
- Sits between u_stg4ma and u_dmem inside diad. MA has default priority.
- A wait counter stops the external port from starving. A bounded lock lets the external port run bursts.
- Drives a combinational stall back into the pipeline whenever MA loses the memory.

---
 rtl/dmem_arb.sv | 139 +++++++++++++
 tb/tb_dmem_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arb.sv
// Data-memory arbiter between the MA pipeline stage and an external requester.
// MA wins by default. Starved or locked external requests take the memory ahead of MA.
module dmem_arb #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 24,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_ma_req,
    input  logic              iw_ma_we,
    input  logic [ADDR_W-1:0] iw_ma_addr,
    input  logic [DATA_W-1:0] iw_ma_wdata,
    output logic              ow_ma_stall,
    output logic              ow_ma_rvalid,
    output logic [DATA_W-1:0] ow_ma_rdata,
    input  logic              iw_ext_req,
    input  logic              iw_ext_we,
    input  logic              iw_ext_lock,
    input  logic [ADDR_W-1:0] iw_ext_addr,
    input  logic [DATA_W-1:0] iw_ext_wdata,
    output logic              ow_ext_gnt,
    output logic              ow_ext_rvalid,
    output logic [DATA_W-1:0] ow_ext_rdata,
    output logic              ow_mem_en,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic [DATA_W-1:0] iw_mem_rdata,
    output logic              ow_ext_forced
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
    localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_MA   = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    logic [3:0] r_wait;
    logic       r_lock;
    logic [7:0] r_lock_cnt;
    owner_t     r_rd_owner;

    logic [3:0] wait_next;
    logic       lock_next;
    logic [7:0] lock_cnt_next;
    owner_t     rd_owner_next;

    logic force_ext;
    logic ma_gnt;
    logic ext_gnt;

    // Grants are qualified by reset so that nothing reaches memory while held in reset.
    always_comb begin
        force_ext = iw_rst && iw_ext_req &&
                    ((r_wait == WAIT_LIM) || (r_lock && (r_lock_cnt < LOCK_LIM)));
        ma_gnt    = iw_rst && !force_ext && iw_ma_req;
        ext_gnt   = force_ext || (iw_rst && !iw_ma_req && iw_ext_req);
    end

    always_comb begin
        ow_mem_en    = ma_gnt || ext_gnt;
        ow_mem_we    = 1'b0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        if (ma_gnt) begin
            ow_mem_we    = iw_ma_we;
            ow_mem_addr  = iw_ma_addr;
            ow_mem_wdata = iw_ma_wdata;
        end else if (ext_gnt) begin
            ow_mem_we    = iw_ext_we;
            ow_mem_addr  = iw_ext_addr;
            ow_mem_wdata = iw_ext_wdata;
        end
    end

    always_comb begin
        ow_ma_stall   = iw_rst && iw_ma_req && !ma_gnt;
        ow_ext_gnt    = ext_gnt;
        ow_ext_forced = force_ext;
        ow_ma_rvalid  = iw_rst && (r_rd_owner == OWN_MA);
        ow_ext_rvalid = iw_rst && (r_rd_owner == OWN_EXT);
        ow_ma_rdata   = ow_ma_rvalid  ? iw_mem_rdata : '0;
        ow_ext_rdata  = ow_ext_rvalid ? iw_mem_rdata : '0;
    end

    always_comb begin
        wait_next = r_wait;
        if (!iw_ext_req || ext_gnt) begin
            wait_next = '0;
        end else if (r_wait != WAIT_LIM) begin
            wait_next = r_wait + 4'd1;
        end
    end

    // At the lock limit the count restarts but the lock stays armed, so MA gets
    // exactly one slot and the burst resumes the cycle after.
    always_comb begin
        lock_next     = r_lock;
        lock_cnt_next = r_lock_cnt;
        if (!iw_ext_req || !iw_ext_lock) begin
            lock_next     = 1'b0;
            lock_cnt_next = '0;
        end else if (r_lock_cnt == LOCK_LIM) begin
            lock_cnt_next = ext_gnt ? 8'd1 : 8'd0;
        end else if (ext_gnt) begin
            lock_next     = 1'b1;
            lock_cnt_next = r_lock_cnt + 8'd1;
        end
    end

    always_comb begin
        rd_owner_next = OWN_NONE;
        if (ma_gnt && !iw_ma_we) begin
            rd_owner_next = OWN_MA;
        end else if (ext_gnt && !iw_ext_we) begin
            rd_owner_next = OWN_EXT;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            r_wait     <= '0;
            r_lock     <= 1'b0;
            r_lock_cnt <= '0;
            r_rd_owner <= OWN_NONE;
        end else begin
            r_wait     <= wait_next;
            r_lock     <= lock_next;
            r_lock_cnt <= lock_cnt_next;
            r_rd_owner <= rd_owner_next;
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a small registered-read memory model on the memory port.
module tb_dmem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ma_req = 1'b0, ma_we = 1'b0;
    logic [23:0] ma_addr = '0, ma_wdata = '0;
    logic        ma_stall, ma_rvalid;
    logic [23:0] ma_rdata;
    logic        ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
    logic [23:0] ext_addr = '0, ext_wdata = '0;
    logic        ext_gnt, ext_rvalid, ext_forced;
    logic [23:0] ext_rdata;
    logic        mem_en, mem_we;
    logic [23:0] mem_addr, mem_wdata;
    logic [23:0] mem_rdata;
    logic [23:0] mem [0:255];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    dmem_arb #(.ADDR_W(24), .DATA_W(24), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
        .iw_clk(clk), .iw_rst(rst),
        .iw_ma_req(ma_req), .iw_ma_we(ma_we), .iw_ma_addr(ma_addr), .iw_ma_wdata(ma_wdata),
        .ow_ma_stall(ma_stall), .ow_ma_rvalid(ma_rvalid), .ow_ma_rdata(ma_rdata),
        .iw_ext_req(ext_req), .iw_ext_we(ext_we), .iw_ext_lock(ext_lock),
        .iw_ext_addr(ext_addr), .iw_ext_wdata(ext_wdata),
        .ow_ext_gnt(ext_gnt), .ow_ext_rvalid(ext_rvalid), .ow_ext_rdata(ext_rdata),
        .ow_mem_en(mem_en), .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
        .iw_mem_rdata(mem_rdata), .ow_ext_forced(ext_forced)
    );

    function automatic logic [23:0] preset(input logic [7:0] a);
        return (a == 8'h10) ? 24'h00ABCD : {16'h5500, a};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= preset(8'(i));
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic mr, input logic mw, input logic [23:0] maddr,
                         input logic [23:0] mwd, input logic er, input logic ew, input logic el,
                         input logic [23:0] eaddr, input logic [23:0] ewd);
        @(negedge clk);
        rst = rs; ma_req = mr; ma_we = mw; ma_addr = maddr; ma_wdata = mwd;
        ext_req = er; ext_we = ew; ext_lock = el; ext_addr = eaddr; ext_wdata = ewd;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ma_idx;
        int          n;
        int          rv_cnt;
        logic        exp_g;
        logic        prev_ext;
        logic        prev_ma;
        logic [23:0] prev_data;

        // Reset with both requesters active: every output held at zero
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b1, 1'b0, 24'h10, 24'h0, 1'b1, 1'b0, 1'b1, 24'h2, 24'h0);
            chk("rst_stall",  32'(ma_stall), 32'h0);
            chk("rst_gnt",    32'(ext_gnt),  32'h0);
            chk("rst_mem_en", 32'(mem_en),   32'h0);
            chk("rst_forced", 32'(ext_forced), 32'h0);
        end
        idle();
        $display("reset: outputs zero while iw_rst=0");

        // 1: MA load, ext idle
        drive(1'b1, 1'b1, 1'b0, 24'h10, 24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        chk("t1_mem_en",   32'(mem_en),   32'h1);
        chk("t1_mem_we",   32'(mem_we),   32'h0);
        chk("t1_mem_addr", 32'(mem_addr), 32'h10);
        chk("t1_stall",    32'(ma_stall), 32'h0);
        idle();
        chk("t1_rvalid",   32'(ma_rvalid), 32'h1);
        chk("t1_rdata",    32'(ma_rdata),  32'h00ABCD);
        chk("t1_ext_rv",   32'(ext_rvalid), 32'h0);
        $display("t1: MA load 0x10 -> %h", ma_rdata);
        idle();

        // 2: MA write burst, ext write starves until MAX_WAIT
        ma_idx = 0;
        for (int c = 1; c <= 6; c++) begin
            drive(1'b1, 1'b1, 1'b1, 24'h40 + 24'(ma_idx), 24'h1000 + 24'(ma_idx),
                  (c <= 5), 1'b1, 1'b0, 24'h3, 24'h5A);
            exp_g = (c == 5);
            chk("t2_ext_gnt", 32'(ext_gnt),    32'(exp_g));
            chk("t2_forced",  32'(ext_forced), 32'(exp_g));
            chk("t2_stall",   32'(ma_stall),   32'(exp_g));
            if (exp_g) begin
                chk("t2_ext_addr",  32'(mem_addr),  32'h3);
                chk("t2_ext_wdata", 32'(mem_wdata), 32'h5A);
            end else begin
                chk("t2_ma_addr", 32'(mem_addr), 32'h40 + 32'(ma_idx));
                ma_idx++;
            end
            $display("t2 cycle %0d: ext_gnt=%0b stall=%0b", c, ext_gnt, ma_stall);
        end
        idle();
        chk("t2_mem3", 32'(mem[3]), 32'h5A);

        // 3: locked ext read burst of 12 against a continuously requesting MA
        n = 0; rv_cnt = 0; prev_ext = 1'b0; prev_ma = 1'b0; prev_data = '0;
        for (int c = 1; c <= 18; c++) begin
            drive(1'b1, (c <= 17), 1'b0, 24'h10, 24'h0,
                  (n < 12), 1'b0, (n < 12), 24'h80 + 24'(n), 24'h0);
            exp_g = ((c >= 5) && (c <= 12)) || ((c >= 14) && (c <= 17));
            chk("t3_ext_gnt", 32'(ext_gnt),    32'(exp_g));
            chk("t3_forced",  32'(ext_forced), 32'(exp_g));
            chk("t3_stall",   32'(ma_stall),   32'(exp_g));
            chk("t3_ext_rv",  32'(ext_rvalid), 32'(prev_ext));
            chk("t3_ext_rd",  32'(ext_rdata),  prev_ext ? 32'(prev_data) : 32'h0);
            chk("t3_ma_rv",   32'(ma_rvalid),  32'(prev_ma));
            chk("t3_ma_rd",   32'(ma_rdata),   prev_ma ? 32'h00ABCD : 32'h0);
            if (ext_rvalid) rv_cnt++;
            $display("t3 cycle %0d: ext_gnt=%0b forced=%0b ext_rv=%0b ma_rv=%0b",
                     c, ext_gnt, ext_forced, ext_rvalid, ma_rvalid);
            prev_ext  = exp_g;
            prev_ma   = (c <= 17) && !exp_g;
            prev_data = 24'h550080 + 24'(n);
            if (exp_g) n++;
        end
        chk("t3_rv_count", 32'(rv_cnt), 32'd12);
        idle();

        // 4: MA read addr 1 then ext read addr 2
        drive(1'b1, 1'b1, 1'b0, 24'h1, 24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        chk("t4_ma_gnt", 32'(mem_addr), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b0, 24'h2, 24'h0);
        chk("t4_ext_gnt",  32'(ext_gnt),    32'h1);
        chk("t4_ma_rv",    32'(ma_rvalid),  32'h1);
        chk("t4_ma_rd",    32'(ma_rdata),   32'h550001);
        chk("t4_ext_rd0",  32'(ext_rdata),  32'h0);
        idle();
        chk("t4_ext_rv",   32'(ext_rvalid), 32'h1);
        chk("t4_ext_rd",   32'(ext_rdata),  32'h550002);
        chk("t4_ma_rd0",   32'(ma_rdata),   32'h0);
        chk("t4_ma_rv0",   32'(ma_rvalid),  32'h0);
        $display("t4: alternating reads returned in grant order");
        idle();

        // 5: reset right after a forced, locked ext read grant
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h10, 24'h0, 1'b1, 1'b0, 1'b1, 24'h2, 24'h0);
            chk("t5_pre_gnt", 32'(ext_gnt), 32'(c == 5));
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b1, 1'b0, 24'h10, 24'h0, 1'b1, 1'b0, 1'b1, 24'h2, 24'h0);
            chk("t5_rst_ext_rv", 32'(ext_rvalid), 32'h0);
            chk("t5_rst_ext_rd", 32'(ext_rdata),  32'h0);
            chk("t5_rst_gnt",    32'(ext_gnt),    32'h0);
            chk("t5_rst_stall",  32'(ma_stall),   32'h0);
            chk("t5_rst_mem_en", 32'(mem_en),     32'h0);
            chk("t5_rst_mem_we", 32'(mem_we),     32'h0);
            chk("t5_rst_forced", 32'(ext_forced), 32'h0);
            chk("t5_rst_ma_rv",  32'(ma_rvalid),  32'h0);
        end
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h10, 24'h0, 1'b1, 1'b0, 1'b1, 24'h2, 24'h0);
            chk("t5_post_gnt", 32'(ext_gnt), 32'(k == 5));
            if (k == 1) chk("t5_post_ext_rv", 32'(ext_rvalid), 32'h0);
            $display("t5 release cycle %0d: ext_gnt=%0b", k, ext_gnt);
        end
        idle();
        idle();

        // 6: ext read with MA idle is granted at once; wait counter stays clear
        drive(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b0, 24'h2, 24'h0);
        chk("t6_gnt",    32'(ext_gnt),    32'h1);
        chk("t6_forced", 32'(ext_forced), 32'h0);
        chk("t6_stall",  32'(ma_stall),   32'h0);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h10, 24'h0, 1'b1, 1'b0, 1'b0, 24'h5, 24'h0);
            chk("t6_wait_gnt", 32'(ext_gnt), 32'(k == 5));
            if (k == 1) begin
                chk("t6_ext_rv", 32'(ext_rvalid), 32'h1);
                chk("t6_ext_rd", 32'(ext_rdata),  32'h550002);
            end
            $display("t6 cycle %0d: ext_gnt=%0b", k, ext_gnt);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
